// File: rtl/mem_lsu_pkg.sv
// Shared types for the load/store unit and the strict-aligned memory it drives.
// Access size, memory error codes, LSU state encoding and size/alignment helpers.
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    DT_BYTE = 2'd0,
    DT_HALF = 2'd1,
    DT_WORD = 2'd2
  } mem_dt_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_RANGE = 2'd2
  } errno_e;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic [2:0] dt_size(input mem_dt_e dt);
    case (dt)
      DT_BYTE: return 3'd1;
      DT_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic dt_aligned(input mem_dt_e dt, input logic [1:0] lsb);
    case (dt)
      DT_BYTE: return 1'b1;
      DT_HALF: return ~lsb[0];
      default: return (lsb == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Core-side request/response channel of the load/store unit.
// master = core (issues requests), slave = LSU.
interface mem_lsu_if;
  import mem_lsu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  mem_dt_e     req_dt;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_dt, req_unsigned, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_dt, req_unsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem.sv
// Strict-aligned word memory: async read, write on the rising edge.
// Misaligned or out-of-range accesses report an error and never write.
module mem
  import mem_lsu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic        clk,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wd,
  input  logic        i_we,
  input  mem_dt_e     i_dt,
  output logic [31:0] o_rd,
  output errno_e      o_err
);

  localparam int AW = $clog2(N);

  logic [31:0]   r_mem [N];
  logic [AW-1:0] w_idx;
  logic          w_in;
  logic [32:0]   w_end;
  logic [31:0]   w_word;
  logic [31:0]   w_shift;
  logic [31:0]   w_wd_sh;
  logic [3:0]    w_be;

  assign w_idx   = i_addr[AW+1:2];
  assign w_in    = (i_addr[31:2] < 30'(N));
  assign w_end   = {1'b0, i_addr} + {30'b0, dt_size(i_dt)} - 33'd1;
  assign w_word  = w_in ? r_mem[w_idx] : 32'd0;
  assign w_shift = w_word >> {i_addr[1:0], 3'b000};
  assign w_wd_sh = i_wd << {i_addr[1:0], 3'b000};

  always_comb begin
    o_err = ERR_NONE;
    if (!dt_aligned(i_dt, i_addr[1:0])) o_err = ERR_ALIGN;
    else if (w_end > 33'(4 * N - 1))    o_err = ERR_RANGE;
  end

  always_comb begin
    case (i_dt)
      DT_BYTE: o_rd = {24'd0, w_shift[7:0]};
      DT_HALF: o_rd = {16'd0, w_shift[15:0]};
      default: o_rd = w_shift;
    endcase
  end

  always_comb begin
    case (i_dt)
      DT_BYTE: w_be = 4'b0001 << i_addr[1:0];
      DT_HALF: w_be = 4'b0011 << i_addr[1:0];
      default: w_be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_we && o_err == ERR_NONE) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd_sh[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_lsu_ext.sv
// Load-result extender: sign- or zero-extends a right-justified byte/half, passes words.
module mem_ext
  import mem_lsu_pkg::*;
(
  input  logic [31:0] i_val,
  input  mem_dt_e     i_dt,
  input  logic        i_unsigned,
  output logic [31:0] o_val
);

  always_comb begin
    case (i_dt)
      DT_BYTE: o_val = {{24{~i_unsigned & i_val[7]}}, i_val[7:0]};
      DT_HALF: o_val = {{16{~i_unsigned & i_val[15]}}, i_val[15:0]};
      default: o_val = i_val;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator: splits misaligned accesses into byte beats toward the
// strict-aligned memory and reassembles/extends load data for the core.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_lsu_if.slave    lsu,
  output logic [31:0] m_addr,
  output logic [31:0] m_wd,
  output logic        m_we,
  output mem_dt_e     m_dt,
  input  logic [31:0] m_rd,
  input  errno_e      m_err
);

  // state      | meaning
  // LSU_IDLE   | waiting for a request, req_ready high
  // LSU_ACCESS | one memory beat per cycle, beat 0 .. nbeats-1
  // LSU_RESP   | response held until resp_ready

  localparam logic [32:0] LP_LIMIT = 33'(4 * N - 1);

  lsu_state_e  r_state;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  mem_dt_e     r_dt;
  logic        r_unsigned;
  logic [31:0] r_asm;
  logic [1:0]  r_beat;
  logic [2:0]  r_nbeats;
  logic        r_err;

  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic [31:0] r_m_addr;
  logic [31:0] r_m_wd;
  logic        r_m_we;
  mem_dt_e     r_m_dt;

  logic        w_aligned;
  logic [2:0]  w_nbeats;
  logic [32:0] w_end;
  logic        w_range_bad;
  logic [1:0]  w_beat_nx;
  logic [7:0]  w_wbyte_nx;
  logic [31:0] w_asm_nx;
  logic        w_err_nx;
  logic        w_last;
  logic [31:0] w_ext;

  assign w_aligned   = dt_aligned(lsu.req_dt, lsu.req_addr[1:0]);
  assign w_nbeats    = w_aligned ? 3'd1 : dt_size(lsu.req_dt);
  assign w_end       = {1'b0, lsu.req_addr} + {30'b0, dt_size(lsu.req_dt)} - 33'd1;
  assign w_range_bad = (w_end > LP_LIMIT);

  assign w_beat_nx  = r_beat + 2'd1;
  assign w_wbyte_nx = r_wdata[{w_beat_nx, 3'b000} +: 8];
  assign w_err_nx   = r_err | (m_err != ERR_NONE);
  assign w_last     = ({1'b0, r_beat} == (r_nbeats - 3'd1));

  always_comb begin
    w_asm_nx = r_asm;
    if (!r_we) begin
      if (r_nbeats == 3'd1) w_asm_nx = m_rd;
      else                  w_asm_nx[{r_beat, 3'b000} +: 8] = m_rd[7:0];
    end
  end

  // Extension runs on the post-capture value so the response register loads on the last beat.
  mem_ext u_ext (
    .i_val      (w_asm_nx),
    .i_dt       (r_dt),
    .i_unsigned (r_unsigned),
    .o_val      (w_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= LSU_IDLE;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_dt         <= DT_BYTE;
      r_unsigned   <= 1'b0;
      r_asm        <= 32'd0;
      r_beat       <= 2'd0;
      r_nbeats     <= 3'd0;
      r_err        <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
      r_m_addr     <= 32'd0;
      r_m_wd       <= 32'd0;
      r_m_we       <= 1'b0;
      r_m_dt       <= DT_WORD;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (lsu.req_valid) begin
            r_we        <= lsu.req_we;
            r_addr      <= lsu.req_addr;
            r_wdata     <= lsu.req_wdata;
            r_dt        <= lsu.req_dt;
            r_unsigned  <= lsu.req_unsigned;
            r_asm       <= 32'd0;
            r_beat      <= 2'd0;
            r_nbeats    <= w_nbeats;
            r_req_ready <= 1'b0;
            if (w_range_bad) begin
              r_err        <= 1'b1;
              r_state      <= LSU_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else begin
              r_err    <= 1'b0;
              r_state  <= LSU_ACCESS;
              r_m_addr <= lsu.req_addr;
              r_m_we   <= lsu.req_we;
              r_m_dt   <= w_aligned ? lsu.req_dt : DT_BYTE;
              r_m_wd   <= w_aligned ? lsu.req_wdata : {24'd0, lsu.req_wdata[7:0]};
            end
          end
        end

        LSU_ACCESS: begin
          r_asm <= w_asm_nx;
          r_err <= w_err_nx;
          if (w_last) begin
            r_state      <= LSU_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err_nx;
            r_resp_rdata <= (r_we || w_err_nx) ? 32'd0 : w_ext;
            r_m_addr     <= 32'd0;
            r_m_wd       <= 32'd0;
            r_m_we       <= 1'b0;
            r_m_dt       <= DT_WORD;
          end else begin
            r_beat   <= w_beat_nx;
            r_m_addr <= r_addr + 32'(w_beat_nx);
            r_m_wd   <= {24'd0, w_wbyte_nx};
          end
        end

        LSU_RESP: begin
          if (lsu.resp_ready) begin
            r_state      <= LSU_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
          end
        end

        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  assign lsu.req_ready  = r_req_ready;
  assign lsu.resp_valid = r_resp_valid;
  assign lsu.resp_rdata = r_resp_rdata;
  assign lsu.resp_err   = r_resp_err;

  // Reset asserted mid-split must block the in-flight beat from reaching memory.
  assign m_we   = r_m_we & rst_n;
  assign m_addr = r_m_addr;
  assign m_wd   = r_m_wd;
  assign m_dt   = r_m_dt;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu attached to a mem instance.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int N = 64;

  logic        clk;
  logic        rst_n;
  logic [31:0] m_addr;
  logic [31:0] m_wd;
  logic        m_we;
  mem_dt_e     m_dt;
  logic [31:0] m_rd;
  errno_e      m_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] wr_q[$];

  mem_lsu_if bus();

  mem_lsu #(.N(N)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .lsu    (bus),
    .m_addr (m_addr),
    .m_wd   (m_wd),
    .m_we   (m_we),
    .m_dt   (m_dt),
    .m_rd   (m_rd),
    .m_err  (m_err)
  );

  mem #(.N(N)) u_mem (
    .clk    (clk),
    .i_addr (m_addr),
    .i_wd   (m_wd),
    .i_we   (m_we),
    .i_dt   (m_dt),
    .o_rd   (m_rd),
    .o_err  (m_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_we === 1'b1) wr_q.push_back(m_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sz(input mem_dt_e dt);
    return (dt == DT_BYTE) ? 1 : (dt == DT_HALF) ? 2 : 4;
  endfunction

  function automatic logic out_of_range(input logic [31:0] addr, input mem_dt_e dt);
    return (longint'(addr) + longint'(sz(dt))) > longint'(4 * N);
  endfunction

  function automatic int beats(input logic [31:0] addr, input mem_dt_e dt);
    if (addr % sz(dt) == 0) return 1;
    return sz(dt);
  endfunction

  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input mem_dt_e dt, input logic uns,
                        input logic [31:0] exp_rd, input int hold);
    exp_t e;
    exp_t got;
    int   n;
    int   lat;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_dt       = dt;
    bus.req_unsigned = uns;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    e.err   = out_of_range(addr, dt);
    e.rdata = (we || e.err) ? 32'd0 : exp_rd;
    e.lat   = e.err ? 1 : 1 + beats(addr, dt);
    sb.push_back(e);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = sb.pop_front();
    chk({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(got.lat));
    chk({tag, "_rdata"}, bus.resp_rdata, got.rdata);
    chk({tag, "_err"}, {31'd0, bus.resp_err}, {31'd0, got.err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, bus.resp_valid}, 32'd1);
      chk({tag, "_hold_rdata"}, bus.resp_rdata, got.rdata);
      chk({tag, "_hold_err"}, {31'd0, bus.resp_err}, {31'd0, got.err});
      chk({tag, "_hold_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    bus.req_dt       = DT_WORD;
    bus.req_unsigned = 1'b0;
    bus.resp_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_we_low", {31'd0, m_we}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_m_we", {31'd0, m_we}, 32'd0);

    // aligned word
    wr_q.delete();
    do_req("st_w10", 1'b1, 32'h10, 32'hDEADBEEF, DT_WORD, 1'b0, 32'd0, 0);
    chk("st_w10_nbeats", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) chk("st_w10_addr", wr_q[0], 32'h10);
    do_req("ld_w10", 1'b0, 32'h10, 32'd0, DT_WORD, 1'b0, 32'hDEADBEEF, 0);

    // signed/unsigned byte and half loads
    do_req("st_w20", 1'b1, 32'h20, 32'h80FF7F01, DT_WORD, 1'b0, 32'd0, 0);
    do_req("ld_b22_s", 1'b0, 32'h22, 32'd0, DT_BYTE, 1'b0, 32'hFFFFFFFF, 0);
    do_req("ld_b22_u", 1'b0, 32'h22, 32'd0, DT_BYTE, 1'b1, 32'h000000FF, 0);
    do_req("ld_b23_s", 1'b0, 32'h23, 32'd0, DT_BYTE, 1'b0, 32'hFFFFFF80, 0);
    do_req("ld_h20_s", 1'b0, 32'h20, 32'd0, DT_HALF, 1'b0, 32'h00007F01, 0);
    do_req("ld_h22_u", 1'b0, 32'h22, 32'd0, DT_HALF, 1'b1, 32'h000080FF, 0);
    do_req("ld_h22_s", 1'b0, 32'h22, 32'd0, DT_HALF, 1'b0, 32'hFFFF80FF, 0);

    // misaligned word
    wr_q.delete();
    do_req("st_w21", 1'b1, 32'h21, 32'h11223344, DT_WORD, 1'b0, 32'd0, 0);
    chk("st_w21_nbeats", 32'(wr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++)
      chk("st_w21_beat_addr", wr_q[i], 32'h21 + 32'(i));
    do_req("ld_w21", 1'b0, 32'h21, 32'd0, DT_WORD, 1'b0, 32'h11223344, 0);
    do_req("ld_w20", 1'b0, 32'h20, 32'd0, DT_WORD, 1'b0, 32'h22334401, 0);
    do_req("ld_b24_u", 1'b0, 32'h24, 32'd0, DT_BYTE, 1'b1, 32'h00000011, 0);

    // misaligned half
    do_req("st_b07", 1'b1, 32'h07, 32'h00000034, DT_BYTE, 1'b0, 32'd0, 0);
    do_req("st_b08", 1'b1, 32'h08, 32'h00000092, DT_BYTE, 1'b0, 32'd0, 0);
    do_req("ld_h07_s", 1'b0, 32'h07, 32'd0, DT_HALF, 1'b0, 32'hFFFF9234, 0);
    do_req("ld_h07_u", 1'b0, 32'h07, 32'd0, DT_HALF, 1'b1, 32'h00009234, 0);

    // range boundary, error path and backpressure
    do_req("st_b_ff", 1'b1, 32'hFF, 32'h0000005A, DT_BYTE, 1'b0, 32'd0, 0);
    do_req("ld_b_ff", 1'b0, 32'hFF, 32'd0, DT_BYTE, 1'b1, 32'h0000005A, 0);
    wr_q.delete();
    do_req("st_w_fe_err", 1'b1, 32'hFE, 32'hCAFEF00D, DT_WORD, 1'b0, 32'd0, 3);
    chk("st_w_fe_no_write", 32'(wr_q.size()), 32'd0);
    do_req("ld_h_ff_err", 1'b0, 32'hFF, 32'd0, DT_HALF, 1'b0, 32'd0, 0);
    do_req("ld_w_wrap_err", 1'b0, 32'hFFFFFFFE, 32'd0, DT_WORD, 1'b0, 32'd0, 0);
    do_req("ld_w_held", 1'b0, 32'h10, 32'd0, DT_WORD, 1'b0, 32'hDEADBEEF, 3);

    // reset asserted during beat 2 of a misaligned word store
    do_req("clr_w40", 1'b1, 32'h40, 32'd0, DT_WORD, 1'b0, 32'd0, 0);
    do_req("clr_w44", 1'b1, 32'h44, 32'd0, DT_WORD, 1'b0, 32'd0, 0);
    wr_q.delete();
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_addr     = 32'h41;
    bus.req_wdata    = 32'hAABBCCDD;
    bus.req_dt       = DT_WORD;
    bus.req_unsigned = 1'b0;
    chk("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_m_we", {31'd0, m_we}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_req_ready_after", {31'd0, bus.req_ready}, 32'd1);
    chk("mid_rst_resp_valid_after", {31'd0, bus.resp_valid}, 32'd0);
    chk("mid_rst_nwrites", 32'(wr_q.size()), 32'd2);
    if (wr_q.size() > 1) begin
      chk("mid_rst_wr0", wr_q[0], 32'h41);
      chk("mid_rst_wr1", wr_q[1], 32'h42);
    end
    do_req("ld_w40_partial", 1'b0, 32'h40, 32'd0, DT_WORD, 1'b0, 32'h00CCDD00, 0);
    do_req("ld_w44_partial", 1'b0, 32'h44, 32'd0, DT_WORD, 1'b0, 32'h00000000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
